// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - mult/div issue sequencer with pipeline stall and watchdog
// Launches the iterative unit, stalls the front end and writes the result or an exception code.
module multdiv_sequencer #(
  parameter int TIMEOUT     = 40,
  parameter int EXC_MULT    = 4,
  parameter int EXC_DIV     = 5,
  parameter int EXC_TIMEOUT = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        tmo_q, tmo_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    rd_d     = rd_q;
    result_d = result_q;
    exc_d    = exc_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          state_d  = START;
          is_div_d = op_is_div;
          rd_d     = op_rd;
          result_d = 32'd0;
          exc_d    = 1'b0;
          tmo_d    = 1'b0;
        end
      end
      START: begin
        cnt_d   = 6'd0;
        state_d = flush ? IDLE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 6'd1;
        // A squash wins over a completing unit; a real result wins over the watchdog.
        if (flush) begin
          state_d = IDLE;
        end else if (md_ready) begin
          state_d  = DONE;
          result_d = md_result;
          exc_d    = md_exception;
        end else if (cnt_q == 6'(TIMEOUT - 1)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall     = ((state_q == IDLE) && op_valid && !flush) ||
                (state_q == START) || (state_q == WAIT);
    busy      = (state_q != IDLE);
    ctrl_MULT = (state_q == START) && !is_div_q;
    ctrl_DIV  = (state_q == START) && is_div_q;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    if (state_q == DONE) begin
      if (tmo_q) begin
        wb_valid = 1'b1;
        wb_rd    = 5'd30;
        wb_data  = 32'(EXC_TIMEOUT);
      end else if (exc_q) begin
        wb_valid = 1'b1;
        wb_rd    = 5'd30;
        wb_data  = is_div_q ? 32'(EXC_DIV) : 32'(EXC_MULT);
      end else if (rd_q != 5'd0) begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = result_q;
      end
    end
  end

endmodule
